// File: rtl/rubiks_polibot_pkg.sv
// Shared constants for the Polibot move receiver: frame header, move encoding
// and frame FSM state codes (also the db_estado encoding).
package rubiks_polibot_pkg;

  localparam logic [7:0] HEADER   = 8'hA5;
  localparam logic [7:0] MAX_CODE = 8'd17;

  typedef enum logic [2:0] {
    FACE_U = 3'd0, FACE_D = 3'd1, FACE_F = 3'd2,
    FACE_B = 3'd3, FACE_L = 3'd4, FACE_R = 3'd5
  } face_t;

  typedef enum logic [1:0] {
    TURN_CW = 2'd0, TURN_CCW = 2'd1, TURN_180 = 2'd2
  } turn_t;

  typedef enum logic [2:0] {
    OCIOSO     = 3'b000,
    ESPERA_CAB = 3'b001,
    RECEBE_N   = 3'b010,
    RECEBE_MOV = 3'b011,
    RECEBE_CHK = 3'b100,
    VALIDA     = 3'b101,
    PRONTO     = 3'b110,
    ERRO       = 3'b111
  } estado_t;

  function automatic logic [4:0] move_code(face_t f, turn_t t);
    return 5'(3 * int'(f) + int'(t));
  endfunction

endpackage

// File: rtl/rubiks_polibot_recebe_movimentos_if.sv
// Control-unit / executor side of the move receiver: request level, UART line,
// buffer read port and status.
interface rubiks_polibot_recebe_movimentos_if #(parameter int ADDR_W = 5);
  logic              receber;
  logic              rx;
  logic [ADDR_W-1:0] end_leitura;
  logic [4:0]        movimento;
  logic [ADDR_W:0]   num_movimentos;
  logic              movimentos_recebidos;
  logic              erro;
  logic [2:0]        db_estado;

  modport master (
    output receber, rx, end_leitura,
    input  movimento, num_movimentos, movimentos_recebidos, erro, db_estado
  );

  modport slave (
    input  receber, rx, end_leitura,
    output movimento, num_movimentos, movimentos_recebidos, erro, db_estado
  );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling with a down-counter,
// one-cycle byte_ok / erro_quadro pulses at the stop-bit sample.
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dado,
  output logic       byte_ok,
  output logic       erro_quadro
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] MEIO = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_estado_t;

  rx_estado_t    estado;
  logic [CW-1:0] cnt;
  logic [2:0]    nbit;
  logic          rx_s1, rx_s2, rx_ant;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= RX_IDLE;
      cnt         <= '0;
      nbit        <= '0;
      dado        <= '0;
      byte_ok     <= 1'b0;
      erro_quadro <= 1'b0;
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_ant      <= 1'b1;
    end else begin
      byte_ok     <= 1'b0;
      erro_quadro <= 1'b0;
      rx_s1       <= rx;
      rx_s2       <= rx_s1;
      rx_ant      <= rx_s2;
      case (estado)
        RX_IDLE: begin
          // edge, not level: a line held low after a bad stop bit must not retrigger
          if (!rx_s2 && rx_ant) begin
            cnt    <= MEIO;
            estado <= RX_START;
          end
        end
        RX_START: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rx_s2) estado <= RX_IDLE;
          else begin
            cnt    <= BIT;
            nbit   <= '0;
            estado <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            dado <= {rx_s2, dado[7:1]};
            cnt  <= BIT;
            if (nbit == 3'd7) estado <= RX_STOP;
            else              nbit   <= nbit + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            byte_ok     <= rx_s2;
            erro_quadro <= !rx_s2;
            estado      <= RX_IDLE;
          end
        end
        default: estado <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rubiks_polibot_recebe_movimentos.sv
// Move-list receiver: validates A5 / N / moves / checksum frames from the host
// solver and keeps the accepted moves in a buffer read by the executor.
module rubiks_polibot_recebe_movimentos
  import rubiks_polibot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_MOV      = 32,
  parameter int ADDR_W       = 5
) (
  input logic clock,
  input logic reset,
  rubiks_polibot_recebe_movimentos_if.slave bus
);

  // state      | meaning
  // OCIOSO     | no request from the control unit
  // ESPERA_CAB | hunting for the 0xA5 header
  // RECEBE_N   | expecting the move count
  // RECEBE_MOV | storing move bytes
  // RECEBE_CHK | expecting the checksum byte
  // VALIDA     | comparing checksum
  // PRONTO     | list accepted, held until a new request
  // ERRO       | one-cycle reject, then resume

  localparam logic [7:0] MAX_MOV_B = 8'(MAX_MOV);

  logic [7:0]      dado;
  logic            byte_ok, erro_quadro;
  estado_t         estado;
  logic [ADDR_W:0] n, idx, num;
  logic [7:0]      soma, chk;
  logic            pronto, erro, receber_q;
  logic            wr_en;
  logic [4:0]      buffer [MAX_MOV];

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock       (clock),
    .reset       (reset),
    .rx          (bus.rx),
    .dado        (dado),
    .byte_ok     (byte_ok),
    .erro_quadro (erro_quadro)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      n         <= '0;
      idx       <= '0;
      soma      <= '0;
      chk       <= '0;
      num       <= '0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
      receber_q <= 1'b0;
    end else begin
      erro      <= 1'b0;
      receber_q <= bus.receber;
      if (!bus.receber && estado != PRONTO) begin
        estado <= OCIOSO;
      end else begin
        case (estado)
          OCIOSO: estado <= ESPERA_CAB;
          ESPERA_CAB: begin
            if (byte_ok && dado == HEADER) estado <= RECEBE_N;
          end
          RECEBE_N: begin
            if (erro_quadro || (byte_ok && (dado == 8'd0 || dado > MAX_MOV_B))) begin
              estado <= ERRO;
              erro   <= 1'b1;
              num    <= '0;
            end else if (byte_ok) begin
              n      <= dado[ADDR_W:0];
              idx    <= '0;
              soma   <= dado;
              estado <= RECEBE_MOV;
            end
          end
          RECEBE_MOV: begin
            if (erro_quadro || (byte_ok && dado > MAX_CODE)) begin
              estado <= ERRO;
              erro   <= 1'b1;
              num    <= '0;
            end else if (byte_ok) begin
              soma <= soma ^ dado;
              idx  <= idx + 1'b1;
              if ((idx + 1'b1) == n) estado <= RECEBE_CHK;
            end
          end
          RECEBE_CHK: begin
            if (erro_quadro) begin
              estado <= ERRO;
              erro   <= 1'b1;
              num    <= '0;
            end else if (byte_ok) begin
              chk    <= dado;
              estado <= VALIDA;
            end
          end
          VALIDA: begin
            if (chk == soma) begin
              num    <= n;
              pronto <= 1'b1;
              estado <= PRONTO;
            end else begin
              estado <= ERRO;
              erro   <= 1'b1;
              num    <= '0;
            end
          end
          PRONTO: begin
            // only a fresh request (rising receber) releases the held list
            if (bus.receber && !receber_q) begin
              num    <= '0;
              pronto <= 1'b0;
              estado <= ESPERA_CAB;
            end
          end
          ERRO:    estado <= ESPERA_CAB;
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

  assign wr_en = bus.receber && (estado == RECEBE_MOV) && byte_ok && (dado <= MAX_CODE);

  always_ff @(posedge clock) begin
    if (wr_en) buffer[idx[ADDR_W-1:0]] <= dado[4:0];
  end

  assign bus.movimento = ({1'b0, bus.end_leitura} < num) ? buffer[bus.end_leitura] : 5'd0;
  assign bus.num_movimentos       = num;
  assign bus.movimentos_recebidos = pronto;
  assign bus.erro                 = erro;
  assign bus.db_estado            = estado;

endmodule

// File: tb/tb_rubiks_polibot_recebe_movimentos.sv
// Directed bench for the move receiver with a fast UART (8 clocks per bit).
module tb_rubiks_polibot_recebe_movimentos;
  import rubiks_polibot_pkg::*;

  localparam int CPB = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rubiks_polibot_recebe_movimentos_if #(.ADDR_W(5)) bus();

  rubiks_polibot_recebe_movimentos #(
    .CLKS_PER_BIT(CPB), .MAX_MOV(32), .ADDR_W(5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int erro_cnt = 0;

  always @(posedge clock) if (bus.erro === 1'b1) erro_cnt++;

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clock) bus.rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    bus.rx = stop;
    repeat (CPB) @(negedge clock);
    bus.rx = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic restart();
    bus.receber = 1'b0;
    repeat (2) @(negedge clock);
    bus.receber = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.receber = 1'b0;
    bus.rx = 1'b1;
    bus.end_leitura = '0;
    #23;
    total++;
    if (bus.db_estado !== 3'b000 || bus.movimentos_recebidos !== 1'b0 ||
        bus.erro !== 1'b0 || bus.num_movimentos !== 6'd0 || bus.movimento !== 5'd0) begin
      bad++;
      $display("FAIL reset_outputs: estado=%b rec=%b erro=%b num=%0d mov=%0d, required all 0",
               bus.db_estado, bus.movimentos_recebidos, bus.erro, bus.num_movimentos, bus.movimento);
    end
    @(negedge clock) reset = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (bus.db_estado !== 3'b000) begin
      bad++;
      $display("FAIL idle_without_request: estado=%b required 000", bus.db_estado);
    end
    bus.receber = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (bus.db_estado !== 3'b001) begin
      bad++;
      $display("FAIL enter_espera_cab: estado=%b required 001", bus.db_estado);
    end
  endtask

  task automatic test_valid_frame();
    logic [4:0] exp_mov [4];
    exp_mov[0] = 5'd0;
    exp_mov[1] = move_code(FACE_F, TURN_CCW);
    exp_mov[2] = move_code(FACE_R, TURN_180);
    exp_mov[3] = 5'd0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h07); send_byte(8'h11);
    fork
      send_byte(8'h15);
      begin
        bit seen = 0;
        for (int c = 0; c < 20 * CPB && !seen; c++) begin
          @(negedge clock);
          if (bus.db_estado === 3'b101) seen = 1;
        end
        total++;
        if (!seen) begin
          bad++;
          $display("FAIL valida_timeout: estado=%b required to reach 101", bus.db_estado);
        end else begin
          total++;
          if (bus.movimentos_recebidos !== 1'b0) begin
            bad++;
            $display("FAIL rec_early: recebidos=%b in VALIDA required 0", bus.movimentos_recebidos);
          end
          @(negedge clock);
          total++;
          if (bus.movimentos_recebidos !== 1'b1 || bus.db_estado !== 3'b110 ||
              bus.num_movimentos !== 6'd3) begin
            bad++;
            $display("FAIL frame_accept: rec=%b estado=%b num=%0d required 1 110 3",
                     bus.movimentos_recebidos, bus.db_estado, bus.num_movimentos);
          end
        end
      end
    join
    for (int a = 0; a < 4; a++) begin
      bus.end_leitura = 5'(a);
      #1;
      total++;
      if (bus.movimento !== exp_mov[a]) begin
        bad++;
        $display("FAIL read_addr%0d: movimento=%0d required %0d", a, bus.movimento, exp_mov[a]);
      end
    end
    bus.receber = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (bus.db_estado !== 3'b110 || bus.movimentos_recebidos !== 1'b1) begin
      bad++;
      $display("FAIL pronto_hold: estado=%b rec=%b required 110 1",
               bus.db_estado, bus.movimentos_recebidos);
    end
  endtask

  task automatic test_bad_checksum();
    int e0;
    restart();
    total++;
    if (bus.num_movimentos !== 6'd0 || bus.db_estado !== 3'b001) begin
      bad++;
      $display("FAIL new_request_clears: num=%0d estado=%b required 0 001",
               bus.num_movimentos, bus.db_estado);
    end
    e0 = erro_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h00);
    repeat (4) @(negedge clock);
    total++;
    if (erro_cnt !== e0 + 1 || bus.num_movimentos !== 6'd0 || bus.db_estado !== 3'b001) begin
      bad++;
      $display("FAIL bad_checksum: erro_cycles=%0d num=%0d estado=%b required 1 0 001",
               erro_cnt - e0, bus.num_movimentos, bus.db_estado);
    end
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h03);
    repeat (4) @(negedge clock);
    bus.end_leitura = 5'd1;
    #1;
    total++;
    if (bus.db_estado !== 3'b110 || bus.num_movimentos !== 6'd2 || bus.movimento !== 5'd5) begin
      bad++;
      $display("FAIL resend_accept: estado=%b num=%0d mov1=%0d required 110 2 5",
               bus.db_estado, bus.num_movimentos, bus.movimento);
    end
    bus.end_leitura = 5'd2;
    #1;
    total++;
    if (bus.movimento !== 5'd0) begin
      bad++;
      $display("FAIL read_past_count: movimento=%0d required 0", bus.movimento);
    end
  endtask

  task automatic test_ignored_and_bad_code();
    int e0;
    restart();
    e0 = erro_cnt;
    send_byte(8'hFF); send_byte(8'h12);
    total++;
    if (bus.db_estado !== 3'b001 || erro_cnt !== e0) begin
      bad++;
      $display("FAIL ignore_non_header: estado=%b erro_cycles=%0d required 001 0",
               bus.db_estado, erro_cnt - e0);
    end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
    repeat (4) @(negedge clock);
    total++;
    if (erro_cnt !== e0 + 1 || bus.db_estado !== 3'b001) begin
      bad++;
      $display("FAIL code18_reject: erro_cycles=%0d estado=%b required 1 001",
               erro_cnt - e0, bus.db_estado);
    end
    send_byte(8'h13);
    total++;
    if (erro_cnt !== e0 + 1 || bus.db_estado !== 3'b001) begin
      bad++;
      $display("FAIL trailing_ignored: erro_cycles=%0d estado=%b required 1 001",
               erro_cnt - e0, bus.db_estado);
    end
  endtask

  task automatic test_bad_count();
    int e0;
    e0 = erro_cnt;
    send_byte(8'hA5); send_byte(8'h00);
    repeat (4) @(negedge clock);
    total++;
    if (erro_cnt !== e0 + 1 || bus.num_movimentos !== 6'd0) begin
      bad++;
      $display("FAIL count_zero: erro_cycles=%0d num=%0d required 1 0",
               erro_cnt - e0, bus.num_movimentos);
    end
    send_byte(8'hA5); send_byte(8'h21);
    repeat (4) @(negedge clock);
    bus.end_leitura = 5'd0;
    #1;
    total++;
    if (erro_cnt !== e0 + 2 || bus.db_estado !== 3'b001 || bus.movimento !== 5'd0) begin
      bad++;
      $display("FAIL count_33: erro_cycles=%0d estado=%b mov=%0d required 2 001 0",
               erro_cnt - e0, bus.db_estado, bus.movimento);
    end
  endtask

  task automatic test_frame_error_and_abort();
    int e0;
    e0 = erro_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h04, 1'b0);
    repeat (4) @(negedge clock);
    total++;
    if (erro_cnt !== e0 + 1 || bus.db_estado !== 3'b001) begin
      bad++;
      $display("FAIL stop_bit_zero: erro_cycles=%0d estado=%b required 1 001",
               erro_cnt - e0, bus.db_estado);
    end
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h04);
    total++;
    if (bus.db_estado !== 3'b011) begin
      bad++;
      $display("FAIL mid_frame_state: estado=%b required 011", bus.db_estado);
    end
    bus.receber = 1'b0;
    @(negedge clock);
    total++;
    if (bus.db_estado !== 3'b000 || erro_cnt !== e0 + 1) begin
      bad++;
      $display("FAIL abort: estado=%b erro_cycles=%0d required 000 1",
               bus.db_estado, erro_cnt - e0);
    end
  endtask

  task automatic test_async_reset_and_full();
    logic [7:0] x;
    bus.receber = 1'b1;
    repeat (3) @(negedge clock);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    #3 reset = 1'b0;
    #1;
    total++;
    if (bus.db_estado !== 3'b000 || bus.movimentos_recebidos !== 1'b0 ||
        bus.erro !== 1'b0 || bus.num_movimentos !== 6'd0) begin
      bad++;
      $display("FAIL async_reset: estado=%b rec=%b erro=%b num=%0d required 000 0 0 0",
               bus.db_estado, bus.movimentos_recebidos, bus.erro, bus.num_movimentos);
    end
    @(negedge clock) reset = 1'b1;
    repeat (3) @(negedge clock);
    x = 8'd32;
    send_byte(8'hA5); send_byte(8'd32);
    for (int i = 0; i < 32; i++) begin
      send_byte(8'(i % 18));
      x = x ^ 8'(i % 18);
    end
    send_byte(x);
    repeat (4) @(negedge clock);
    bus.end_leitura = 5'd31;
    #1;
    total++;
    if (bus.db_estado !== 3'b110 || bus.num_movimentos !== 6'd32 || bus.movimento !== 5'd13) begin
      bad++;
      $display("FAIL max_frame: estado=%b num=%0d mov31=%0d required 110 32 13",
               bus.db_estado, bus.num_movimentos, bus.movimento);
    end
    bus.end_leitura = 5'd17;
    #1;
    total++;
    if (bus.movimento !== 5'd17) begin
      bad++;
      $display("FAIL max_frame_mov17: movimento=%0d required 17", bus.movimento);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_ignored_and_bad_code();
    test_bad_count();
    test_frame_error_and_abort();
    test_async_reset_and_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
